forwarding_control_unit: RTL and testbench

FORWARDING_CONTROL_UNIT -- requirements
Module: forwarding_control_unit

---
 rtl/forwarding_control_unit_pkg.sv | 13 +
 rtl/forwarding_control_unit_if.sv | 34 +++
 rtl/forwarding_compare.sv | 34 +++
 rtl/forwarding_control_unit.sv | 121 ++++++++++++
 tb/tb_forwarding_control_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/forwarding_control_unit_pkg.sv
// Shared forwarding constants: operand-mux select encodings used by
// the forwarding unit and by any EX-stage operand mux.
package forwarding_control_unit_pkg;

  typedef enum logic [1:0] {
    SEL_REG = 2'b00,
    SEL_MEM = 2'b01,
    SEL_WB  = 2'b10
  } fwd_sel_e;

  localparam int NB_SEL = 2;

endpackage

// File: rtl/forwarding_control_unit_if.sv
// ID-stage request bundle and forwarding/hazard response bundle.
interface forwarding_control_unit_if #(
  parameter int NB_ADDR  = 5,
  parameter int NB_COUNT = 32
);
  import forwarding_control_unit_pkg::*;

  logic                id_valid;
  logic [NB_ADDR-1:0]  id_rs;
  logic [NB_ADDR-1:0]  id_rt;
  logic [NB_ADDR-1:0]  id_dest;
  logic                id_reg_write;
  logic                id_mem_read;
  logic [NB_SEL-1:0]   select_a;
  logic [NB_SEL-1:0]   select_b;
  logic                stall;
  logic                bubble;
  logic [NB_COUNT-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_dest,
    output id_reg_write, id_mem_read,
    input  select_a, select_b, stall, bubble,
    input  stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dest,
    input  id_reg_write, id_mem_read,
    output select_a, select_b, stall, bubble,
    output stall_count
  );

endinterface

// File: rtl/forwarding_compare.sv
// Priority compare of one EX-stage source register against MEM and WB
// destinations; MEM wins, register 0 never forwards.
module forwarding_compare
  import forwarding_control_unit_pkg::*;
#(
  parameter int NB_ADDR = 5
) (
  input  logic [NB_ADDR-1:0] src,
  input  logic [NB_ADDR-1:0] mem_dest,
  input  logic               mem_reg_write,
  input  logic [NB_ADDR-1:0] wb_dest,
  input  logic               wb_reg_write,
  output fwd_sel_e           sel
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_reg_write && (mem_dest != '0)
              && (mem_dest == src);
    wb_hit  = wb_reg_write && (wb_dest != '0)
              && (wb_dest == src);
  end

  always_comb begin
    sel = SEL_REG;
    if (mem_hit)
      sel = SEL_MEM;
    else if (wb_hit)
      sel = SEL_WB;
  end

endmodule

// File: rtl/forwarding_control_unit.sv
// Shadow EX/MEM/WB state, operand forwarding selects, load-use stall
// detection and a stall-cycle counter.
module forwarding_control_unit
  import forwarding_control_unit_pkg::*;
#(
  parameter int NB_ADDR  = 5,
  parameter int NB_COUNT = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  forwarding_control_unit_if.slave  bus
);

  logic [NB_ADDR-1:0]  ex_rs_q, ex_rs_d;
  logic [NB_ADDR-1:0]  ex_rt_q, ex_rt_d;
  logic [NB_ADDR-1:0]  ex_dest_q, ex_dest_d;
  logic                ex_rw_q, ex_rw_d;
  logic                ex_mr_q, ex_mr_d;
  logic [NB_ADDR-1:0]  mem_dest_q, mem_dest_d;
  logic                mem_rw_q, mem_rw_d;
  logic [NB_ADDR-1:0]  wb_dest_q, wb_dest_d;
  logic                wb_rw_q, wb_rw_d;
  logic [NB_COUNT-1:0] stall_count_q, stall_count_d;

  logic     stall;
  fwd_sel_e sel_a;
  fwd_sel_e sel_b;

  always_comb begin
    stall = bus.id_valid && ex_mr_q && (ex_dest_q != '0)
            && ((ex_dest_q == bus.id_rs)
             || (ex_dest_q == bus.id_rt));
  end

  forwarding_compare #(.NB_ADDR(NB_ADDR)) u_cmp_a (
    .src           (ex_rs_q),
    .mem_dest      (mem_dest_q),
    .mem_reg_write (mem_rw_q),
    .wb_dest       (wb_dest_q),
    .wb_reg_write  (wb_rw_q),
    .sel           (sel_a)
  );

  forwarding_compare #(.NB_ADDR(NB_ADDR)) u_cmp_b (
    .src           (ex_rt_q),
    .mem_dest      (mem_dest_q),
    .mem_reg_write (mem_rw_q),
    .wb_dest       (wb_dest_q),
    .wb_reg_write  (wb_rw_q),
    .sel           (sel_b)
  );

  always_comb begin
    ex_rs_d       = ex_rs_q;
    ex_rt_d       = ex_rt_q;
    ex_dest_d     = ex_dest_q;
    ex_rw_d       = ex_rw_q;
    ex_mr_d       = ex_mr_q;
    mem_dest_d    = mem_dest_q;
    mem_rw_d      = mem_rw_q;
    wb_dest_d     = wb_dest_q;
    wb_rw_d       = wb_rw_q;
    stall_count_d = stall_count_q;
    if (enable) begin
      mem_dest_d = ex_dest_q;
      mem_rw_d   = ex_rw_q;
      wb_dest_d  = mem_dest_q;
      wb_rw_d    = mem_rw_q;
      // A stalled or empty ID slot enters EX as a bubble
      if (stall || !bus.id_valid) begin
        ex_rs_d   = '0;
        ex_rt_d   = '0;
        ex_dest_d = '0;
        ex_rw_d   = 1'b0;
        ex_mr_d   = 1'b0;
      end else begin
        ex_rs_d   = bus.id_rs;
        ex_rt_d   = bus.id_rt;
        ex_dest_d = bus.id_dest;
        ex_rw_d   = bus.id_reg_write;
        ex_mr_d   = bus.id_mem_read;
      end
      if (stall)
        stall_count_d = stall_count_q + NB_COUNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_dest_q     <= '0;
      ex_rw_q       <= 1'b0;
      ex_mr_q       <= 1'b0;
      mem_dest_q    <= '0;
      mem_rw_q      <= 1'b0;
      wb_dest_q     <= '0;
      wb_rw_q       <= 1'b0;
      stall_count_q <= '0;
    end else begin
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_dest_q     <= ex_dest_d;
      ex_rw_q       <= ex_rw_d;
      ex_mr_q       <= ex_mr_d;
      mem_dest_q    <= mem_dest_d;
      mem_rw_q      <= mem_rw_d;
      wb_dest_q     <= wb_dest_d;
      wb_rw_q       <= wb_rw_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.select_a    = sel_a;
  assign bus.select_b    = sel_b;
  assign bus.stall       = stall;
  assign bus.bubble      = stall;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_control_unit.sv
// Directed bench for forwarding_control_unit: forwarding, load-use
// stalls, register 0, enable hold and reset during a stall.
module tb_forwarding_control_unit;

  localparam int NB_ADDR  = 5;
  localparam int NB_COUNT = 32;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  int   total = 0;
  int   bad   = 0;

  forwarding_control_unit_if #(
    .NB_ADDR(NB_ADDR), .NB_COUNT(NB_COUNT)
  ) bus ();

  forwarding_control_unit #(
    .NB_ADDR(NB_ADDR), .NB_COUNT(NB_COUNT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input int rs, input int rt,
                       input int rd, input logic rw,
                       input logic mr);
    bus.id_valid     = v;
    bus.id_rs        = NB_ADDR'(rs);
    bus.id_rt        = NB_ADDR'(rt);
    bus.id_dest      = NB_ADDR'(rd);
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    nop();
    tick(); tick(); tick();
  endtask

  task automatic chk_sel(input string tag,
                         input logic [1:0] a,
                         input logic [1:0] b);
    chk({tag, "_sel_a"}, 32'(bus.select_a), 32'(a));
    chk({tag, "_sel_b"}, 32'(bus.select_b), 32'(b));
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    nop();
    tick(); tick();
    reset = 1'b0;
    #1;
    chk_sel("reset", 2'b00, 2'b00);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_bubble", 32'(bus.bubble), 32'd0);
    chk("reset_count", bus.stall_count, 32'd0);

    // add $3,$1,$2 ; sub $4,$3,$5
    drive(1'b1, 1, 2, 3, 1'b1, 1'b0); tick();
    drive(1'b1, 3, 5, 4, 1'b1, 1'b0); tick();
    chk_sel("ex_mem", 2'b01, 2'b00);
    chk("ex_mem_stall", 32'(bus.stall), 32'd0);
    flush();

    // add $3 ; nop ; or $6,$7,$3
    drive(1'b1, 1, 2, 3, 1'b1, 1'b0); tick();
    nop(); tick();
    drive(1'b1, 7, 3, 6, 1'b1, 1'b0); tick();
    chk_sel("mem_wb", 2'b00, 2'b10);
    flush();

    // add $3 ; add $3 ; sub $8,$3,$3
    drive(1'b1, 1, 2, 3, 1'b1, 1'b0); tick();
    drive(1'b1, 1, 2, 3, 1'b1, 1'b0); tick();
    drive(1'b1, 3, 3, 8, 1'b1, 1'b0); tick();
    chk_sel("prio", 2'b01, 2'b01);
    flush();

    // lw $2,0($1) ; add $4,$2,$2
    drive(1'b1, 1, 2, 2, 1'b1, 1'b1); tick();
    drive(1'b1, 2, 2, 4, 1'b1, 1'b0);
    chk("lu_stall", 32'(bus.stall), 32'd1);
    chk("lu_bubble", 32'(bus.bubble), 32'd1);
    chk("lu_count0", bus.stall_count, 32'd0);
    tick();
    chk("lu_stall_gone", 32'(bus.stall), 32'd0);
    chk("lu_count1", bus.stall_count, 32'd1);
    tick();
    chk_sel("lu_fwd", 2'b10, 2'b10);
    flush();

    // lw $0 ; reader of $0
    drive(1'b1, 1, 0, 0, 1'b1, 1'b1); tick();
    drive(1'b1, 0, 0, 5, 1'b1, 1'b0);
    chk("r0_stall", 32'(bus.stall), 32'd0);
    tick();
    chk_sel("r0", 2'b00, 2'b00);
    chk("r0_count", bus.stall_count, 32'd1);
    flush();

    // load-use with enable low for 3 cycles
    drive(1'b1, 1, 2, 2, 1'b1, 1'b1); tick();
    drive(1'b1, 2, 2, 4, 1'b1, 1'b0);
    chk("hold_stall0", 32'(bus.stall), 32'd1);
    enable = 1'b0;
    tick(); tick(); tick();
    chk("hold_stall3", 32'(bus.stall), 32'd1);
    chk("hold_count", bus.stall_count, 32'd1);
    enable = 1'b1;
    tick();
    chk("rel_stall", 32'(bus.stall), 32'd0);
    chk("rel_count", bus.stall_count, 32'd2);
    tick();
    chk_sel("rel_fwd", 2'b10, 2'b10);
    flush();

    // lw $2 ; lw $3,0($2) ; add $4,$3,$3
    drive(1'b1, 1, 2, 2, 1'b1, 1'b1); tick();
    drive(1'b1, 2, 3, 3, 1'b1, 1'b1);
    chk("b2b_stall1", 32'(bus.stall), 32'd1);
    tick(); tick();
    chk("b2b_lw_sel_a", 32'(bus.select_a), 32'd2);
    drive(1'b1, 3, 3, 4, 1'b1, 1'b0);
    chk("b2b_stall2", 32'(bus.stall), 32'd1);
    tick(); tick();
    chk_sel("b2b_fwd", 2'b10, 2'b10);
    chk("b2b_count", bus.stall_count, 32'd4);
    flush();

    // reset during a pending stall
    drive(1'b1, 1, 2, 2, 1'b1, 1'b1); tick();
    drive(1'b1, 2, 2, 4, 1'b1, 1'b0);
    chk("rst_pre_stall", 32'(bus.stall), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_count", bus.stall_count, 32'd0);
    chk_sel("rst", 2'b00, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
